// File: rtl/game_flow_ctrl.sv
// Match sequencer: IDLE -> COUNTDOWN -> FIGHT -> result screen, with a per-second timebase and
// frame-synchronous commit to the renderer. Optional `PAUSE_EN adds a level `pause` input for FIGHT.
module game_flow_ctrl #(
  parameter int unsigned CLK_HZ            = 25_000_000,
  parameter int unsigned COUNTDOWN_SECONDS = 5,
  parameter int unsigned FIGHT_SECONDS     = 99,
  parameter int unsigned RESULT_SECONDS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_start,
  input  logic [2:0] player1_health,
  input  logic [2:0] player2_health,
`ifdef PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] game_state,
  output logic [6:0] game_duration,
  output logic       fight_active,
  output logic       round_reset
);

  localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [6:0]    CD_LAST    = 7'(COUNTDOWN_SECONDS - 1);
  localparam logic [6:0]    FIGHT_INIT = 7'(FIGHT_SECONDS);
  localparam logic [6:0]    RES_LAST   = 7'(RESULT_SECONDS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FIGHT     = 3'd2,
    S_P1_WIN    = 3'd3,
    S_P2_WIN    = 3'd4,
    S_EQ        = 3'd5
  } state_t;

  state_t        r_st, w_st_nxt;
  logic [6:0]    r_dur, w_dur_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic          w_tick, w_freeze, w_rr_nxt, w_health_end;

  always_comb begin
    w_freeze = 1'b0;
`ifdef PAUSE_EN
    w_freeze = (r_st == S_FIGHT) && pause;
`endif
    w_tick       = (r_pre == PRE_LAST) && !w_freeze;
    w_health_end = (player1_health == 3'd0) || (player2_health == 3'd0);
    w_st_nxt     = r_st;
    w_dur_nxt    = r_dur;
    w_rr_nxt     = 1'b0;

    case (r_st)
      S_IDLE: begin
        if (start) begin
          w_st_nxt  = S_COUNTDOWN;
          w_dur_nxt = '0;
          w_rr_nxt  = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (w_tick) begin
          if (r_dur == CD_LAST) begin
            w_st_nxt  = S_FIGHT;
            w_dur_nxt = FIGHT_INIT;
          end else begin
            w_dur_nxt = r_dur + 7'd1;
          end
        end
      end
      S_FIGHT: begin
        // Timer expiry and KO share one verdict: the health compare decides the winner.
        if (w_health_end || (w_tick && r_dur == 7'd1) || r_dur == 7'd0) begin
          w_dur_nxt = '0;
          if (player1_health > player2_health)      w_st_nxt = S_P1_WIN;
          else if (player2_health > player1_health) w_st_nxt = S_P2_WIN;
          else                                      w_st_nxt = S_EQ;
        end else if (w_tick) begin
          w_dur_nxt = r_dur - 7'd1;
        end
      end
      S_P1_WIN, S_P2_WIN, S_EQ: begin
        if (start) begin
          w_st_nxt  = S_COUNTDOWN;
          w_dur_nxt = '0;
          w_rr_nxt  = 1'b1;
        end else if (w_tick) begin
          if (r_dur == RES_LAST) begin
            w_st_nxt  = S_IDLE;
            w_dur_nxt = '0;
          end else begin
            w_dur_nxt = r_dur + 7'd1;
          end
        end
      end
      default: begin
        w_st_nxt  = S_IDLE;
        w_dur_nxt = '0;
      end
    endcase

    // Restart the second on every state change so each state's first second is full length.
    if (w_st_nxt != r_st)     w_pre_nxt = '0;
    else if (w_freeze)        w_pre_nxt = r_pre;
    else if (r_pre == PRE_LAST) w_pre_nxt = '0;
    else                      w_pre_nxt = r_pre + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= S_IDLE;
      r_dur <= '0;
      r_pre <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_dur <= w_dur_nxt;
      r_pre <= w_pre_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_state    <= '0;
      game_duration <= '0;
      fight_active  <= 1'b0;
      round_reset   <= 1'b0;
    end else begin
      round_reset <= w_rr_nxt;
      if (frame_start) begin
        game_state    <= r_st;
        game_duration <= r_dur;
        fight_active  <= (r_st == S_FIGHT);
      end
    end
  end

endmodule
